// File: rtl/tem_input_conditioner.sv
// TEM trigger conditioner: sync, stable-time filter, edge strobes, rise holdoff.
// Optional rejected-pulse counter built when TEM_GLITCH_CNT_EN is defined.
module tem_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 100,
  parameter int HOLDOFF_CYC = 5000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tem_in,
  output logic        tem_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        busy_o,
  output logic [15:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    LOW,
    QUAL_RISE,
    HIGH,
    QUAL_FALL
  } state_t;

  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_CYC);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_CYC);

  logic [SYNC_STAGES-1:0] sync;
  logic                   tem_s;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       filt, filt_n;
  logic [CNT_W-1:0]       hold, hold_n;
  logic                   tem_n, rise_n, fall_n;
  logic                   rej;

  assign tem_s = sync[SYNC_STAGES-1];

  // metastability chain; keeps running while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], tem_in};
  end

  // next state: the count check wins so a pulse of exactly FILT_CYC
  // samples (entry sample included) is accepted
  always_comb begin
    state_n = state;
    filt_n  = filt;
    tem_n   = tem_o;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    rej     = 1'b0;
    if (rise_o)         hold_n = HOLD_MAX;
    else if (hold != 0) hold_n = hold - 1'b1;
    else                hold_n = hold;
    if (!enable) begin
      state_n = LOW;
      filt_n  = '0;
      tem_n   = 1'b0;
      hold_n  = '0;
    end else begin
      unique case (state)
        LOW: begin
          if (tem_s) begin
            state_n = QUAL_RISE;
            filt_n  = CNT_W'(1);
          end
        end
        QUAL_RISE: begin
          if (filt == FILT_MAX) begin
            state_n = HIGH;
            filt_n  = '0;
            tem_n   = 1'b1;
            rise_n  = !busy_o;
          end else if (!tem_s) begin
            state_n = LOW;
            filt_n  = '0;
            rej     = 1'b1;
          end else begin
            filt_n  = filt + 1'b1;
          end
        end
        HIGH: begin
          if (!tem_s) begin
            state_n = QUAL_FALL;
            filt_n  = CNT_W'(1);
          end
        end
        QUAL_FALL: begin
          if (filt == FILT_MAX) begin
            state_n = LOW;
            filt_n  = '0;
            tem_n   = 1'b0;
            fall_n  = 1'b1;
          end else if (tem_s) begin
            state_n = HIGH;
            filt_n  = '0;
            rej     = 1'b1;
          end else begin
            filt_n  = filt + 1'b1;
          end
        end
        default: begin
          state_n = LOW;
          filt_n  = '0;
        end
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOW;
      filt   <= '0;
      hold   <= '0;
      tem_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      filt   <= filt_n;
      hold   <= hold_n;
      tem_o  <= tem_n;
      rise_o <= rise_n;
      fall_o <= fall_n;
      busy_o <= (hold_n != 0);
    end
  end

`ifdef TEM_GLITCH_CNT_EN
  logic [15:0] glitch;

  // saturating count of rejected pulses; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      glitch <= '0;
    else if (rej && glitch != 16'hFFFF)
      glitch <= glitch + 1'b1;
  end

  assign glitch_cnt_o = glitch;
`else
  logic unused_rej;
  assign unused_rej   = rej;
  assign glitch_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_tem_input_conditioner.sv
// Directed bench for tem_input_conditioner at default parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tem_input_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        tem_in = 1'b0;
  logic        tem_o, rise_o, fall_o, busy_o;
  logic [15:0] glitch_cnt_o;

`ifdef TEM_GLITCH_CNT_EN
  localparam int GC = 1;
`else
  localparam int GC = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int both = 0;
  int exp_g = 0;
  int r0, f0;

  tem_input_conditioner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .tem_in       (tem_in),
    .tem_o        (tem_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .busy_o       (busy_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  always #5 clk = ~clk;

  // strobe tally, reads the value held during the cycle just ended
  always @(posedge clk) begin
    if (rise_o) rise_cnt++;
    if (fall_o) fall_cnt++;
    if (rise_o && fall_o) both = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(1);
    check("rst_tem", 32'(tem_o), 0);
    check("rst_rise", 32'(rise_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_glitch", 32'(glitch_cnt_o), 0);
    enable = 1'b1;
    rst_n  = 1'b1;
    tick(3);

    // 1: clean rise, holdoff window, clean fall
    tem_in = 1'b1;
    tick(102);
    check("t1_early_rise", 32'(rise_o), 0);
    check("t1_early_tem", 32'(tem_o), 0);
    tick(1);
    check("t1_rise", 32'(rise_o), 1);
    check("t1_tem", 32'(tem_o), 1);
    check("t1_busy_same", 32'(busy_o), 0);
    tick(1);
    check("t1_rise_1cyc", 32'(rise_o), 0);
    check("t1_busy_on", 32'(busy_o), 1);
    tick(4999);
    check("t1_busy_last", 32'(busy_o), 1);
    tick(1);
    check("t1_busy_off", 32'(busy_o), 0);
    tem_in = 1'b0;
    tick(102);
    check("t1_tem_hold", 32'(tem_o), 1);
    tick(1);
    check("t1_fall", 32'(fall_o), 1);
    check("t1_tem_low", 32'(tem_o), 0);
    check("t1_rise_cnt", 32'(rise_cnt), 1);

    // 2: 50-clock glitch rejected
    tick(5);
    tem_in = 1'b1;
    tick(50);
    tem_in = 1'b0;
    exp_g += GC;
    tick(200);
    check("t2_tem", 32'(tem_o), 0);
    check("t2_rise_cnt", 32'(rise_cnt), 1);
    check("t2_fall_cnt", 32'(fall_cnt), 1);
    check("t2_glitch", 32'(glitch_cnt_o), 32'(exp_g));

    // 3: rise inside holdoff suppressed, holdoff not restarted
    tem_in = 1'b1;
    tick(103);
    check("t3_rise_a", 32'(rise_o), 1);
    tick(897);
    tem_in = 1'b0;
    tick(103);
    check("t3_fall_a", 32'(fall_o), 1);
    tick(1897);
    tem_in = 1'b1;
    tick(103);
    check("t3_tem_b", 32'(tem_o), 1);
    check("t3_rise_b_sup", 32'(rise_o), 0);
    check("t3_busy_b", 32'(busy_o), 1);
    tick(897);
    tem_in = 1'b0;
    tick(1103);
    check("t3_busy_end", 32'(busy_o), 1);
    tick(1);
    check("t3_busy_clr", 32'(busy_o), 0);
    tick(896);
    tem_in = 1'b1;
    tick(103);
    check("t3_rise_c", 32'(rise_o), 1);
    check("t3_rise_cnt", 32'(rise_cnt), 2);
    tick(97);
    tem_in = 1'b0;
    tick(4802);
    tem_in = 1'b1;
    tick(102);
    check("t3_bnd_busy", 32'(busy_o), 0);
    tick(1);
    check("t3_bnd_rise", 32'(rise_o), 1);
    tick(1);
    check("t3_bnd_busy_on", 32'(busy_o), 1);

    // 6: disable while high and busy, then re-enable with input high
    f0 = fall_cnt;
    enable = 1'b0;
    tick(1);
    check("t6_tem", 32'(tem_o), 0);
    check("t6_busy", 32'(busy_o), 0);
    check("t6_fall", 32'(fall_o), 0);
    tick(5);
    check("t6_fall_cnt", 32'(fall_cnt), 32'(f0));
    enable = 1'b1;
    tick(100);
    check("t6_early_rise", 32'(rise_o), 0);
    tick(1);
    check("t6_rise", 32'(rise_o), 1);

    // 4: exact-width pulse accepted, one shorter rejected
    tem_in = 1'b0;
    tick(3);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(3);
    tem_in = 1'b1;
    tick(100);
    tem_in = 1'b0;
    tick(3);
    check("t4_rise_100", 32'(rise_o), 1);
    tick(101);
    check("t4_fall_100", 32'(fall_o), 1);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);
    r0 = rise_cnt;
    tem_in = 1'b1;
    tick(99);
    tem_in = 1'b0;
    exp_g += GC;
    tick(200);
    check("t4_tem_99", 32'(tem_o), 0);
    check("t4_rise_99", 32'(rise_cnt), 32'(r0));
    check("t4_glitch", 32'(glitch_cnt_o), 32'(exp_g));

    // 5: reset mid-qualification, fresh qualification afterwards
    tem_in = 1'b1;
    tick(62);
    rst_n = 1'b0;
    #1;
    exp_g = 0;
    check("t5_tem", 32'(tem_o), 0);
    check("t5_busy", 32'(busy_o), 0);
    check("t5_glitch", 32'(glitch_cnt_o), 32'(exp_g));
    tick(2);
    rst_n = 1'b1;
    tick(102);
    check("t5_early_rise", 32'(rise_o), 0);
    tick(1);
    check("t5_rise", 32'(rise_o), 1);

    check("excl_strobes", 32'(both), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
